// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin arbiter for the shared-SRAM breq/bgrt handshake. It issues at
//   most one registered, one-hot grant, inserts one dead cycle between owners,
//   and can optionally force a release after a tenure limit.
//
//   Optional feature macro: ARB_TENURE_LIMIT_EN
//     defined   : an owner that has held the bus for MAX_TENURE cycles is
//                 released (with a one-cycle preempt pulse) when another
//                 requester is waiting.
//     undefined : no forced release; preempt is tied low and the tenure
//                 counter is not built.
//
//   Parameters
//     NREQ       number of requesters (2..8); index 0 = CPU, 1 = DMAC
//     MAX_TENURE grant cycles before a forced release (2..255)
//
//   Ports
//     clk     in   rising-edge clock
//     rst     in   asynchronous, active-high reset
//     breq    in   per-requester level request, held for a whole transaction
//     bgrt    out  registered grant, one-hot or all-zero
//     owner   out  index of the current grantee; holds through the dead
//                  cycle, 0 when idle
//     busy    out  |bgrt
//     preempt out  one-cycle pulse coinciding with a forced release
module bus_rr_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned MAX_TENURE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         breq,
  output logic [NREQ-1:0]         bgrt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    preempt
);

  localparam int unsigned OW = $clog2(NREQ);

  // Out-of-range parameters are rejected at elaboration time.
  if (NREQ < 2 || NREQ > 8 || MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_param_check
    $error("bus_rr_arbiter: NREQ must be 2..8 and MAX_TENURE 2..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] bgrt_q,  bgrt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q,  last_d;

`ifdef ARB_TENURE_LIMIT_EN
  localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);

  logic [7:0] tenure_q, tenure_d;
  logic       preempt_q, preempt_d;
`endif

  // Round-robin search: scan from last+1 upward (wrapping), first request wins.
  logic            rr_found;
  logic [OW-1:0]   rr_idx;
  logic [NREQ-1:0] rr_onehot;
  int unsigned     rr_cand;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      rr_cand = (32'(last_q) + i) % NREQ;
      if (!rr_found && breq[OW'(rr_cand)]) begin
        rr_found = 1'b1;
        rr_idx   = OW'(rr_cand);
      end
    end
    rr_onehot         = '0;
    rr_onehot[rr_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    bgrt_d  = bgrt_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef ARB_TENURE_LIMIT_EN
    tenure_d  = tenure_q;
    preempt_d = 1'b0;
`endif

    unique case (state_q)
      // Leaving the dead cycle arbitrates exactly like IDLE; the releasing
      // owner sits at 'last', so it is searched last and only wins alone.
      ST_IDLE, ST_GAP: begin
        if (rr_found) begin
          state_d = ST_GRANT;
          bgrt_d  = rr_onehot;
          owner_d = rr_idx;
          last_d  = rr_idx;
`ifdef ARB_TENURE_LIMIT_EN
          tenure_d = '0;
`endif
        end else begin
          state_d = ST_IDLE;
          bgrt_d  = '0;
          owner_d = '0;
        end
      end

      ST_GRANT: begin
`ifdef ARB_TENURE_LIMIT_EN
        if (tenure_q != 8'hFF) begin
          tenure_d = tenure_q + 8'd1;
        end
`endif
        if (!breq[owner_q]) begin
          state_d = ST_GAP;
          bgrt_d  = '0;
        end
`ifdef ARB_TENURE_LIMIT_EN
        // Forced release only when someone else is actually waiting.
        else if (tenure_q == TENURE_LAST && |(breq & ~bgrt_q)) begin
          state_d   = ST_GAP;
          bgrt_d    = '0;
          preempt_d = 1'b1;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
        bgrt_d  = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bgrt_q  <= '0;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
`ifdef ARB_TENURE_LIMIT_EN
      tenure_q  <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bgrt_q  <= bgrt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef ARB_TENURE_LIMIT_EN
      tenure_q  <= tenure_d;
      preempt_q <= preempt_d;
`endif
    end
  end

  assign bgrt  = bgrt_q;
  assign owner = owner_q;
  assign busy  = |bgrt_q;
`ifdef ARB_TENURE_LIMIT_EN
  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

  localparam int N  = 2;
  localparam int MT = 4;
`ifdef ARB_TENURE_LIMIT_EN
  localparam bit TEN_EN = 1'b1;
`else
  localparam bit TEN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] breq;
  logic [N-1:0] bgrt;
  logic [0:0]   owner;
  logic         busy;
  logic         preempt;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.NREQ(N), .MAX_TENURE(MT)) dut (
    .clk     (clk),
    .rst     (rst),
    .breq    (breq),
    .bgrt    (bgrt),
    .owner   (owner),
    .busy    (busy),
    .preempt (preempt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who holds the bus (-1 = nobody), last winner,
  // grant-cycle count, visible owner index and the preempt pulse.
  int m_own, m_last, m_ten, m_owner;
  bit m_pre;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_bgrt();
    logic [N-1:0] e;
    e = '0;
    if (m_own >= 0) e[m_own] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = N - 1; m_ten = 0; m_owner = 0; m_pre = 1'b0;
  endtask

  // One rising edge seen by the model with request vector r.
  task automatic model_edge(input logic [N-1:0] r);
    int w;
    m_pre = 1'b0;
    if (m_own >= 0) begin
      if (!r[m_own]) begin
        m_own = -1;                       // release; owner index stays visible
      end else if (TEN_EN && m_ten == MT - 1 && (r & ~(N'(1) << m_own)) != 0) begin
        m_own = -1;
        m_pre = 1'b1;
      end else if (m_ten < 255) begin
        m_ten++;
      end
    end else begin
      w = pick(r);
      if (w >= 0) begin
        m_own = w; m_last = w; m_ten = 0; m_owner = w;
      end else begin
        m_owner = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/bgrt"},    bgrt,    exp_bgrt());
    check({tag, "/owner"},   owner,   m_owner);
    check({tag, "/busy"},    busy,    (m_own >= 0));
    check({tag, "/preempt"}, preempt, m_pre);
  endtask

  task automatic cyc(input logic [N-1:0] r, input string tag);
    breq = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    breq = '0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    int held [N];
    int len  [N];
    int grants[$];
    int gaps[$];
    int zero_run;
    logic [N-1:0] prev;
    int pre_cnt, bad_cnt;

    rst = 1'b1;
    breq = '0;
    #3;
    model_reset();
    check_all("por");
    #4 rst = 1'b0;

    // Single requester (DMAC)
    cyc(2'b10, "single_req");
    check("single_bgrt", bgrt, 2'b10);
    check("single_owner", owner, 1);
    cyc(2'b10, "single_hold");
    cyc(2'b00, "single_rel");
    check("single_rel_bgrt", bgrt, 2'b00);
    cyc(2'b00, "single_idle");
    check("single_idle_owner", owner, 0);

    // Contention right after reset: CPU first, then DMAC after one dead cycle
    do_reset();
    cyc(2'b11, "cont_first");
    check("cont_first_bgrt", bgrt, 2'b01);
    cyc(2'b11, "cont_hold");
    cyc(2'b10, "cont_rel");
    check("cont_gap_bgrt", bgrt, 2'b00);
    cyc(2'b10, "cont_hand");
    check("cont_hand_bgrt", bgrt, 2'b10);
    cyc(2'b00, "cont_end");
    cyc(2'b00, "cont_idle");

    // One-cycle pulse in IDLE still gets a one-cycle grant
    cyc(2'b01, "pulse");
    check("pulse_bgrt", bgrt, 2'b01);
    cyc(2'b00, "pulse_rel");
    cyc(2'b00, "pulse_idle");

    // Fairness: both masters run back-to-back 3-cycle transactions
    do_reset();
    r = 2'b11;
    held = '{default: 0};
    prev = '0;
    zero_run = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(r, "fair");
      if (bgrt != '0 && prev == '0) begin
        grants.push_back(int'(owner));
        gaps.push_back(zero_run);
      end
      zero_run = (bgrt == '0) ? zero_run + 1 : 0;
      prev = bgrt;
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (m_own == i) held[i]++;
          if (held[i] == 3) r[i] = 1'b0;
        end else begin
          r[i] = 1'b1;
          held[i] = 0;
        end
      end
    end
    check("fair_count_ok", (grants.size() >= 4), 1);
    if (grants.size() >= 4) begin
      for (int g = 0; g < 4; g++) begin
        check("fair_order", grants[g], g % 2);
        if (g > 0) check("fair_gap", gaps[g], 1);
      end
    end
    cyc(2'b00, "fair_drain0");
    cyc(2'b00, "fair_drain1");

    // Tenure: DMAC holds, CPU joins
    do_reset();
    cyc(2'b10, "ten_start");
    pre_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(2'b11, "tenure");
      if (preempt) pre_cnt++;
    end
    check("ten_preempt_pulses", pre_cnt, TEN_EN ? 1 : 0);
    check("ten_final_bgrt", bgrt, TEN_EN ? 2'b01 : 2'b10);

    // DMAC alone for 40 cycles: never preempted
    do_reset();
    pre_cnt = 0;
    bad_cnt = 0;
    cyc(2'b10, "alone_start");
    for (int c = 0; c < 40; c++) begin
      cyc(2'b10, "alone");
      if (preempt) pre_cnt++;
      if (bgrt != 2'b10) bad_cnt++;
    end
    check("alone_preempt", pre_cnt, 0);
    check("alone_bgrt_lost", bad_cnt, 0);

    // Reset between edges during a DMAC grant
    check("rst_mid_pre_bgrt", bgrt, 2'b10);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_bgrt", bgrt, 2'b00);
    check("rst_mid_owner", owner, 0);
    check("rst_mid_busy", busy, 1'b0);
    breq = 2'b11;
    @(posedge clk);
    #3 rst = 1'b0;
    cyc(2'b11, "rst_after");
    check("rst_after_bgrt", bgrt, 2'b01);
    cyc(2'b00, "rst_after_rel");
    cyc(2'b00, "rst_after_idle");

    // Randomised traffic against the model
    do_reset();
    r = '0;
    held = '{default: 0};
    len  = '{default: 1};
    for (int c = 0; c < 500; c++) begin
      cyc(r, "rand");
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if (m_own == i) held[i]++;
          if (held[i] >= len[i]) r[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r[i] = 1'b1;
          held[i] = 0;
          len[i] = int'($urandom_range(1, 7));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin responder for the shared-SRAM `breq`/`bgrt` request/grant handshake. Collects bus requests from up to `NREQ` initiators (CPU, DMAC, future masters) and returns at most one registered grant. Sits between the bus initiators and the SRAM address/data muxes, which steer on its one-hot grant vector. Adds a mandatory dead cycle between owners and an optional tenure limit so a long DMA burst cannot starve the CPU.

## Interface
Parameters:
- `NREQ`, 2, number of requesters; index 0 = CPU, 1 = DMAC; legal range 2..8.
- `MAX_TENURE`, 16, grant cycles before forced release; only used with `ARB_TENURE_LIMIT_EN`; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `breq`  in  NREQ  per-requester bus request; level, held for the whole transaction.
- `bgrt`  out  NREQ  registered grant; one-hot or all-zero.
- `owner`  out  $clog2(NREQ)  index of current grantee; 0 when idle.
- `busy`  out  1  `|bgrt`.
- `preempt`  out  1  one-cycle pulse on a forced release.

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: at an edge where `breq != 0`, pick a winner and enter GRANT with `bgrt[winner]=1`. If `breq == 0`, stay in IDLE.
- Winner selection: round-robin.
  - Search starts at `last+1` modulo `NREQ`; first set bit wins.
  - `last` updates to the winner when the grant is issued.
  - Reset value of `last` is `NREQ-1`, so index 0 wins the first contention.
- GRANT, normal release: at an edge where `breq[owner]==0`, clear `bgrt`, enter GAP.
  - Requests from other indices never affect the current grant, except through preemption.
- GAP: exactly one cycle with `bgrt==0`.
  - At the edge leaving GAP, arbitrate as in IDLE: grant directly if any request is pending, else go to IDLE.
  - The releasing requester may win again only if no other index is requesting.
- Tenure counter, 8-bit:
  - Cleared on grant.
  - Increments every GRANT cycle.
  - Saturates at 255.
- `owner` is registered alongside `bgrt`; it holds its last value during GAP and returns to 0 on entry to IDLE.
- `busy` is combinational from `bgrt`.

## Timing
- Reset values: `bgrt=0`, `owner=0`, `busy=0`, `preempt=0`, state IDLE, `last=NREQ-1`, counter 0.
- Reset asserted mid-grant drops `bgrt` immediately, without waiting for a clock edge.
- Grant latency from IDLE: `breq` sampled high at edge e → `bgrt` high after edge e (1 cycle).
- Release latency: `breq[owner]` sampled low at edge e → `bgrt` low after edge e.
- Handoff: the next owner's `bgrt` rises after edge e+1, so the bus is dead for exactly one cycle.
- A requester must not drive the bus until it samples its `bgrt` high. It must drop its address/write-enable in the same cycle it drops `breq`.
- Simultaneous requests in IDLE: the round-robin order decides; exactly one grant is issued.
- A requester that pulses `breq` for one cycle in IDLE still receives a one-cycle grant and then releases normally.

## Configuration
- `ARB_TENURE_LIMIT_EN` defined:
  - In GRANT, at the edge where counter == `MAX_TENURE-1` and some other `breq` bit is set, clear `bgrt` and pulse `preempt` high for that one cycle.
  - Then enter GAP; the next arbitration follows normal round-robin.
  - The preempted requester keeps `breq` high and waits for its next grant.
  - If no other requester is pending, the grant is held indefinitely.
- Undefined:
  - No forced release; `preempt` is tied 0.
  - The counter logic is removed.

## Test plan
- Single requester: after reset, raise `breq=2'b10` → `bgrt=2'b10` one cycle later, `owner=1`. Drop `breq` → `bgrt=0` next cycle, then IDLE, `owner=0`.
- Contention after reset: `breq=2'b11` at the first edge → `bgrt=2'b01`. CPU drops `breq[0]` → one-cycle gap → `bgrt=2'b10`.
- Fairness: both requesters hold for repeated 3-cycle transactions → grants alternate 0,1,0,1 with exactly one dead cycle between each.
- Tenure (macro on, `MAX_TENURE=4`): DMAC holds, CPU raises `breq[0]` → DMAC `bgrt` drops after its 4th grant cycle, `preempt` high for 1 cycle, then CPU is granted after the gap.
- No preemption when alone (macro on): DMAC holds 40 cycles with `breq[0]=0` → `bgrt=2'b10` throughout, `preempt` never asserts.
- Reset mid-grant: assert `rst` between edges while `bgrt=2'b10` → `bgrt=0` immediately. After `rst` deasserts with `breq=2'b11` → index 0 is granted first.
